// File: rtl/cache_bus_mem_responder_if.sv
// ----------------------------------------------------------------------------
// cache_bus_mem_responder_if
//
// Cache-to-memory burst bus between the cache AXI interface block (master)
// and a memory responder (slave). Read and write channels are independent.
//
// Signals (directions seen from the responder):
//   ce_i          in   chip enable; gates acceptance of new reads and writes
//   sel_i[3:0]    in   write byte enables, bit i -> byte i
//   ren_i         in   read request, held for the whole burst
//   rready_i      in   initiator ready for a read beat
//   raddr_i[31:0] in   read byte address, sampled at accept
//   rlen_i[3:0]   in   read beats-1
//   rdata_o[31:0] out  read beat data
//   rdata_valid_o out  read beat valid
//   wen_i         in   write request, held for the whole burst
//   wvalid_i      in   write beat valid
//   waddr_i[31:0] in   per-beat write byte address
//   wdata_i[31:0] in   per-beat write data
//   wlast_i       in   final write beat marker
//   wlen_i[3:0]   in   write beats-1 (informational)
//   wdata_resp_o  out  one-cycle per-beat write response
//   rd_busy_o     out  read engine active
//   wr_busy_o     out  write engine active
// ----------------------------------------------------------------------------
interface cache_bus_mem_responder_if;
    logic        ce_i;
    logic [3:0]  sel_i;
    logic        ren_i;
    logic        rready_i;
    logic [31:0] raddr_i;
    logic [3:0]  rlen_i;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        wen_i;
    logic        wvalid_i;
    logic [31:0] waddr_i;
    logic [31:0] wdata_i;
    logic        wlast_i;
    logic [3:0]  wlen_i;
    logic        wdata_resp_o;
    logic        rd_busy_o;
    logic        wr_busy_o;

    modport master (
        output ce_i, sel_i, ren_i, rready_i, raddr_i, rlen_i,
        output wen_i, wvalid_i, waddr_i, wdata_i, wlast_i, wlen_i,
        input  rdata_o, rdata_valid_o, wdata_resp_o, rd_busy_o, wr_busy_o
    );

    modport slave (
        input  ce_i, sel_i, ren_i, rready_i, raddr_i, rlen_i,
        input  wen_i, wvalid_i, waddr_i, wdata_i, wlast_i, wlen_i,
        output rdata_o, rdata_valid_o, wdata_resp_o, rd_busy_o, wr_busy_o
    );
endinterface

// File: rtl/cache_bus_mem_responder.sv
// ----------------------------------------------------------------------------
// cache_bus_mem_responder
//
// Slave end of the cache-to-memory burst bus. Serves 1..16 beat reads and
// per-beat acknowledged writes from an internal word-addressed RAM with
// configurable read and write latency. Read and write engines run
// independently and may both touch the RAM on the same edge; a read that
// collides with a write to the same word returns the old contents.
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset (RAM contents are kept)
//   bus_io  --   slave modport of cache_bus_mem_responder_if
//
// Parameters:
//   MEM_WORDS      RAM depth in 32-bit words (power of two)
//   ADDR_W         log2(MEM_WORDS); word index = addr[ADDR_W+1:2]
//   READ_LATENCY   cycles from read accept to first rdata_valid_o (1..15)
//   WRITE_LATENCY  cycles from beat accept to wdata_resp_o (1..15)
// ----------------------------------------------------------------------------
module cache_bus_mem_responder #(
    parameter int unsigned MEM_WORDS     = 4096,
    parameter int unsigned ADDR_W        = 12,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    cache_bus_mem_responder_if.slave  bus_io
);

    // Final value of the wait counters before the first beat / response is
    // registered. Only meaningful when the latency is at least 2.
    localparam logic [3:0] RLatLast = 4'(READ_LATENCY  >= 2 ? READ_LATENCY  - 2 : 0);
    localparam logic [3:0] WLatLast = 4'(WRITE_LATENCY >= 2 ? WRITE_LATENCY - 2 : 0);

    typedef enum logic [1:0] {RIdle, RWait, RBurst} r_state_e;
    typedef enum logic [1:0] {WIdle, WWait, WResp}  w_state_e;

    logic [31:0] mem [MEM_WORDS];

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    r_state_e          r_state_q;
    logic [ADDR_W-1:0] r_base_q;
    logic [3:0]        r_len_q;
    logic [3:0]        r_beat_q;
    logic [3:0]        r_lat_q;
    logic [31:0]       rdata_q;
    logic              rvalid_q;

    logic [ADDR_W-1:0] raddr_idx;
    logic [ADDR_W-1:0] r_cur_idx;
    logic [ADDR_W-1:0] r_nxt_idx;
    logic              r_accept;

    assign raddr_idx = bus_io.raddr_i[ADDR_W+1:2];
    // Beat addressing wraps naturally in ADDR_W bits.
    assign r_cur_idx = r_base_q + ADDR_W'(r_beat_q);
    assign r_nxt_idx = r_cur_idx + ADDR_W'(1);
    assign r_accept  = bus_io.ce_i & bus_io.ren_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= RIdle;
            r_base_q  <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_lat_q   <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            case (r_state_q)
                RIdle: begin
                    if (r_accept) begin
                        r_base_q <= raddr_idx;
                        r_len_q  <= bus_io.rlen_i;
                        r_beat_q <= '0;
                        r_lat_q  <= '0;
                        if (READ_LATENCY <= 1) begin
                            // Latency 1: the first beat is fetched on the accept edge.
                            rdata_q   <= mem[raddr_idx];
                            rvalid_q  <= 1'b1;
                            r_state_q <= RBurst;
                        end else begin
                            r_state_q <= RWait;
                        end
                    end
                end
                RWait: begin
                    if (!bus_io.ren_i) begin
                        r_state_q <= RIdle;
                    end else if (r_lat_q == RLatLast) begin
                        rdata_q   <= mem[r_cur_idx];
                        rvalid_q  <= 1'b1;
                        r_state_q <= RBurst;
                    end else begin
                        r_lat_q <= r_lat_q + 4'd1;
                    end
                end
                RBurst: begin
                    if (!bus_io.ren_i) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= RIdle;
                    end else if (bus_io.rready_i) begin
                        if (r_beat_q == r_len_q) begin
                            rvalid_q  <= 1'b0;
                            r_state_q <= RIdle;
                        end else begin
                            // Prefetch the next beat; sampling mem here gives the
                            // pre-write value if the writer hits this word too.
                            r_beat_q <= r_beat_q + 4'd1;
                            rdata_q  <= mem[r_nxt_idx];
                        end
                    end
                    // rready_i low: data and valid hold.
                end
                default: begin
                    rvalid_q  <= 1'b0;
                    r_state_q <= RIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    w_state_e          w_state_q;
    logic [ADDR_W-1:0] w_idx_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_mask_q;
    logic [3:0]        w_lat_q;
    logic              wresp_q;

    logic              w_accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_widx;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;

    assign w_accept = (w_state_q == WIdle) & bus_io.ce_i & bus_io.wen_i & bus_io.wvalid_i;

    // The RAM is written on the same edge that raises wdata_resp_o.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = w_idx_q;
        mem_wdata = w_data_q;
        mem_wmask = w_mask_q;
        if (WRITE_LATENCY <= 1) begin
            mem_we    = w_accept;
            mem_widx  = bus_io.waddr_i[ADDR_W+1:2];
            mem_wdata = bus_io.wdata_i;
            mem_wmask = bus_io.sel_i;
        end else begin
            mem_we = (w_state_q == WWait) && (w_lat_q == WLatLast);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= WIdle;
            w_idx_q   <= '0;
            w_data_q  <= '0;
            w_mask_q  <= '0;
            w_lat_q   <= '0;
            wresp_q   <= 1'b0;
        end else begin
            case (w_state_q)
                WIdle: begin
                    if (w_accept) begin
                        w_idx_q  <= bus_io.waddr_i[ADDR_W+1:2];
                        w_data_q <= bus_io.wdata_i;
                        w_mask_q <= bus_io.sel_i;
                        w_lat_q  <= '0;
                        if (WRITE_LATENCY <= 1) begin
                            wresp_q   <= 1'b1;
                            w_state_q <= WResp;
                        end else begin
                            w_state_q <= WWait;
                        end
                    end
                end
                WWait: begin
                    // Once accepted the beat completes even if wen_i drops.
                    if (w_lat_q == WLatLast) begin
                        wresp_q   <= 1'b1;
                        w_state_q <= WResp;
                    end else begin
                        w_lat_q <= w_lat_q + 4'd1;
                    end
                end
                WResp: begin
                    wresp_q   <= 1'b0;
                    w_state_q <= WIdle;
                end
                default: begin
                    wresp_q   <= 1'b0;
                    w_state_q <= WIdle;
                end
            endcase
        end
    end

    // RAM has no reset; a write landing on a reset edge is dropped so no
    // word changes without a matching response.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) begin
                    mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_io.rdata_o       = rdata_q;
    assign bus_io.rdata_valid_o = rvalid_q;
    assign bus_io.wdata_resp_o  = wresp_q;
    assign bus_io.rd_busy_o     = (r_state_q != RIdle);
    assign bus_io.wr_busy_o     = (w_state_q != WIdle);

    // Address bits outside the word index, wlast_i (every beat returns to
    // idle regardless) and wlen_i carry no information for this responder.
    logic unused_bits;
    assign unused_bits = ^{bus_io.raddr_i[31:ADDR_W+2], bus_io.raddr_i[1:0],
                           bus_io.waddr_i[31:ADDR_W+2], bus_io.waddr_i[1:0],
                           bus_io.wlast_i, bus_io.wlen_i};

endmodule
